// File: rtl/piccolo_pkg.sv
// Shared Piccolo constants: FSM states, S-box, diffusion matrix M and GF(2^4) arithmetic.
// Also holds the round permutation used when PICCOLO_ROUND_PERM_EN is defined.
package piccolo_pkg;

  localparam int BLK_W = 64;
  localparam int BR_W  = 16;

  typedef enum logic [2:0] {IDLE, F0, F1, F2, DONE} state_t;

  // x^4 + x + 1 with the x^4 term implied
  localparam logic [3:0] GF_POLY = 4'h3;

  localparam logic [3:0] SBOX [16] = '{
    4'hE, 4'h4, 4'hB, 4'h2, 4'h3, 4'h8, 4'h0, 4'h9,
    4'h1, 4'hA, 4'h7, 4'hF, 4'h6, 4'hC, 4'h5, 4'hD
  };

  localparam logic [3:0] M_COEF [4][4] = '{
    '{4'h2, 4'h3, 4'h1, 4'h1},
    '{4'h1, 4'h2, 4'h3, 4'h1},
    '{4'h1, 4'h1, 4'h2, 4'h3},
    '{4'h3, 4'h1, 4'h1, 4'h2}
  };

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] t;
    p = 4'h0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ t;
      t = t[3] ? ({t[2:0], 1'b0} ^ GF_POLY) : {t[2:0], 1'b0};
    end
    return p;
  endfunction

  // Bytes x0..x7 (x0 = MSB) reordered to (x2,x7,x4,x1,x6,x3,x0,x5)
  function automatic logic [BLK_W-1:0] round_perm(input logic [BLK_W-1:0] x);
    return {x[47:40], x[7:0], x[31:24], x[55:48], x[15:8], x[39:32], x[63:56], x[23:16]};
  endfunction

endpackage

// File: rtl/piccolo_f_unit.sv
// Combinational Piccolo F-function: nibble S-box, diffusion matrix M, nibble S-box.
module piccolo_f_unit
  import piccolo_pkg::*;
(
  input  logic [BR_W-1:0] x,
  output logic [BR_W-1:0] f
);

  logic [BR_W-1:0] s1;

  // Nibble 0 is x[15:12], matching the first element of each M row
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_nib
      logic [3:0] mix;

      assign s1[BR_W-1-4*gi -: 4] = SBOX[x[BR_W-1-4*gi -: 4]];

      always_comb begin
        mix = 4'h0;
        for (int j = 0; j < 4; j++) begin
          mix = mix ^ gf_mul(M_COEF[gi][j], s1[BR_W-1-4*j -: 4]);
        end
      end

      assign f[BR_W-1-4*gi -: 4] = SBOX[mix];
    end
  endgenerate

endmodule

// File: rtl/piccolo_round_sched.sv
// One Piccolo round over a single shared F unit: X0 then X2, with round-key XOR.
// Define PICCOLO_ROUND_PERM_EN to apply the round permutation on out_data.
module piccolo_round_sched
  import piccolo_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_data,
  input  logic [31:0]      rk,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             busy
);

  state_t          state, state_next;
  logic [BLK_W-1:0] blk;
  logic [31:0]      key;
  logic [BR_W-1:0]  freg;
  logic [BR_W-1:0]  f_in;
  logic [BR_W-1:0]  f_out;
  logic [BLK_W-1:0] res;
  logic             take;

  piccolo_f_unit u_f (
    .x (f_in),
    .f (f_out)
  );

  always_comb begin
    state_next = state;
    f_in       = blk[63:48];
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = F0;
      end
      F0: state_next = F1;
      F1: begin
        f_in       = blk[31:16];
        state_next = F2;
      end
      F2: state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_next = in_valid ? F0 : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign take = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      blk   <= '0;
      key   <= '0;
      freg  <= '0;
      res   <= '0;
    end else begin
      state <= state_next;
      if (take) begin
        blk <= in_data;
        key <= rk;
      end
      case (state)
        F0: freg <= f_out;
        F1: begin
          res[47:32] <= blk[47:32] ^ freg ^ key[31:16];
          freg       <= f_out;
        end
        F2: begin
          res[63:48] <= blk[63:48];
          res[31:16] <= blk[31:16];
          res[15:0]  <= blk[15:0] ^ freg ^ key[15:0];
        end
        default: ;
      endcase
    end
  end

`ifdef PICCOLO_ROUND_PERM_EN
  assign out_data = round_perm(res);
`else
  assign out_data = res;
`endif

endmodule
